tlul_simple_host: RTL



---
 rtl/tlul_pkg.sv | 42 ++++
 rtl/tlul_simple_host.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/tlul_pkg.sv
// TL-UL bus payload types and opcodes shared by hosts, devices and benches.
package tlul_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned MaskW = DataW / 8;
  localparam int unsigned SrcW  = 8;

  // A-channel opcodes
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  // D-channel opcodes
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic             a_valid;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [1:0]       a_size;
    logic [SrcW-1:0]  a_source;
    logic [AddrW-1:0] a_address;
    logic [MaskW-1:0] a_mask;
    logic [DataW-1:0] a_data;
    logic             d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic             d_valid;
    logic [2:0]       d_opcode;
    logic [2:0]       d_param;
    logic [1:0]       d_size;
    logic [SrcW-1:0]  d_source;
    logic             d_sink;
    logic [DataW-1:0] d_data;
    logic             d_error;
    logic             a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_simple_host.sv
// Single-outstanding TL-UL host: turns one req/gnt/rvalid transaction into a
// TL-UL A request and returns the matching D response, with a response
// timeout that drains a late reply so a hung device cannot stall the master.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   req_i/gnt_o                master request / accept (gnt only in IDLE)
//   we_i, addr_i, wdata_i, be_i  transaction fields, captured at grant
//   rvalid_o, rdata_o, err_o   one-cycle response pulse with held data/error
//   tl_o, tl_i                 TL-UL host-to-device / device-to-host channels
module tlul_simple_host
  import tlul_pkg::*;
#(
  parameter int unsigned SourceId      = 0,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, RESP, DRAIN} state_e;

  state_e            state;
  logic              gnt_q;
  logic              a_valid_q;
  logic              d_ready_q;
  logic              rvalid_q;
  logic [DataW-1:0]  rdata_q;
  logic              err_q;
  logic              we_q;
  logic [2:0]        opcode_q;
  logic [AddrW-1:0]  addr_q;
  logic [DataW-1:0]  wdata_q;
  logic [MaskW-1:0]  be_q;
  logic [CntW-1:0]   cnt;

  logic rsp_err_c;
  logic timeout_c;
  logic unused_d;

  // Response error: device error, foreign source, or opcode not matching the request kind
  always_comb begin
    rsp_err_c = tl_i.d_error
              | (tl_i.d_source != SrcW'(SourceId))
              | (we_q ? (tl_i.d_opcode != AccessAck) : (tl_i.d_opcode != AccessAckData));
  end

  // Expiry on the last allowed RESP cycle; a same-cycle d_valid wins
  always_comb begin
    timeout_c = (TimeoutCycles != 0)
              && (cnt == CntW'(TimeoutCycles - 1))
              && !tl_i.d_valid;
  end

  assign unused_d = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink};

  // Transaction state machine; every output is a register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      gnt_q     <= 1'b1;
      a_valid_q <= 1'b0;
      d_ready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      opcode_q  <= Get;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      cnt       <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q      <= we_i;
            addr_q    <= addr_i;
            wdata_q   <= wdata_i;
            be_q      <= be_i;
            opcode_q  <= !we_i ? Get : ((be_i == 4'hF) ? PutFullData : PutPartialData);
            a_valid_q <= 1'b1;
            gnt_q     <= 1'b0;
            state     <= ADDR;
          end
        end
        // a_valid is held until accepted; no timeout here
        ADDR: begin
          if (tl_i.a_ready) begin
            a_valid_q <= 1'b0;
            d_ready_q <= 1'b1;
            cnt       <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (tl_i.d_valid) begin
            d_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= we_q ? '0 : tl_i.d_data;
            err_q     <= rsp_err_c;
            gnt_q     <= 1'b1;
            state     <= IDLE;
          end else if (timeout_c) begin
            rvalid_q  <= 1'b1;
            rdata_q   <= '0;
            err_q     <= 1'b1;
            state     <= DRAIN;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        // Keep d_ready up to swallow the late reply already owed to us
        DRAIN: begin
          if (tl_i.d_valid) begin
            d_ready_q <= 1'b0;
            gnt_q     <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt_o    = gnt_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid_q;
    tl_o.a_opcode  = opcode_q;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = SrcW'(SourceId);
    tl_o.a_address = addr_q;
    tl_o.a_mask    = be_q;
    tl_o.a_data    = wdata_q;
    tl_o.d_ready   = d_ready_q;
  end

endmodule
